// File: rtl/match_result_collector.sv
// Aligns per-packet results from parallel lookup sources, resolves priority
// (lowest index wins) and emits one handshaked action per packet.
module match_result_collector #(
  parameter int C_NUM_SRC          = 2,
  parameter int C_OUT_PORT_WIDTH   = 8,
  parameter int C_MATCH_ADDR_WIDTH = 10,
  parameter int C_FIFO_DEPTH       = 4,
  parameter int C_TIMEOUT          = 255,
  localparam int SW = (C_NUM_SRC > 1) ? $clog2(C_NUM_SRC) : 1
) (
  input  logic                                       clk,
  input  logic                                       resetn,
  input  logic [C_NUM_SRC-1:0]                       src_valid,
  output logic [C_NUM_SRC-1:0]                       src_ready,
  input  logic [C_NUM_SRC-1:0]                       src_match,
  input  logic [C_NUM_SRC*C_OUT_PORT_WIDTH-1:0]      src_port,
  input  logic [C_NUM_SRC*C_OUT_PORT_WIDTH-1:0]      src_vport,
  input  logic [2*C_NUM_SRC-1:0]                     src_type,
  input  logic [C_NUM_SRC*C_MATCH_ADDR_WIDTH-1:0]    src_match_addr,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       out_match,
  output logic [C_OUT_PORT_WIDTH-1:0]                out_port,
  output logic [C_OUT_PORT_WIDTH-1:0]                out_vport,
  output logic [1:0]                                 out_type,
  output logic [C_MATCH_ADDR_WIDTH-1:0]              out_match_addr,
  output logic [SW-1:0]                              out_src,
  output logic                                       timeout_err,
  output logic [31:0]                                hit_cnt,
  output logic [31:0]                                miss_cnt
);

  localparam int W  = C_OUT_PORT_WIDTH;
  localparam int A  = C_MATCH_ADDR_WIDTH;
  localparam int PW = $clog2(C_FIFO_DEPTH);
  localparam int EW = 1 + 2 * W + 2 + A;

  // entry layout: {match, port, vport, type, addr}
  logic [EW-1:0]        mem_q    [C_NUM_SRC][C_FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q [C_NUM_SRC];
  logic [PW-1:0]        rd_ptr_q [C_NUM_SRC];
  logic [PW:0]          cnt_q    [C_NUM_SRC];
  logic [PW:0]          cnt_d    [C_NUM_SRC];
  logic [EW-1:0]        head     [C_NUM_SRC];
  logic [EW-1:0]        src_entry[C_NUM_SRC];
  logic [C_NUM_SRC-1:0] src_ready_q, push, pop, not_empty;
  logic                 all_rdy, any_ne, load, timeout;
  logic [15:0]          wd_q;
  logic                 found;
  logic [SW-1:0]        win_idx;
  logic [EW-1:0]        win_entry;

  logic                 out_valid_q, out_match_q, timeout_err_q;
  logic [W-1:0]         out_port_q, out_vport_q;
  logic [1:0]           out_type_q;
  logic [A-1:0]         out_addr_q;
  logic [SW-1:0]        out_src_q;
  logic [31:0]          hit_q, miss_q;

  always_comb begin
    for (int i = 0; i < C_NUM_SRC; i++) begin
      not_empty[i] = (cnt_q[i] != '0);
      push[i]      = src_valid[i] & src_ready_q[i];
      head[i]      = mem_q[i][rd_ptr_q[i]];
      src_entry[i] = {src_match[i], src_port[i*W +: W], src_vport[i*W +: W],
                      src_type[2*i +: 2], src_match_addr[i*A +: A]};
    end
    all_rdy = &not_empty;
    any_ne  = |not_empty;
    load    = all_rdy && (!out_valid_q || out_ready);
    timeout = !load && any_ne && (wd_q == 16'(C_TIMEOUT));
    for (int i = 0; i < C_NUM_SRC; i++) begin
      pop[i]   = load | (timeout & not_empty[i]);
      cnt_d[i] = cnt_q[i] + (PW+1)'(push[i]) - (PW+1)'(pop[i]);
    end
  end

  // Priority resolve: a miss leaves win_entry zero, which zeroes all data fields.
  always_comb begin
    found     = 1'b0;
    win_idx   = '0;
    win_entry = '0;
    for (int i = 0; i < C_NUM_SRC; i++) begin
      if (!found && head[i][EW-1]) begin
        found     = 1'b1;
        win_idx   = SW'(i);
        win_entry = head[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < C_NUM_SRC; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= src_entry[i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < C_NUM_SRC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      src_ready_q <= '0;
    end else begin
      for (int i = 0; i < C_NUM_SRC; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        cnt_q[i]       <= cnt_d[i];
        src_ready_q[i] <= (cnt_d[i] != (PW+1)'(C_FIFO_DEPTH));
      end
    end
  end

  // Watchdog only advances while a packet is partially assembled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout;
      if (load || !any_ne || timeout) wd_q <= '0;
      else if (!all_rdy)              wd_q <= wd_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_match_q <= 1'b0;
      out_port_q  <= '0;
      out_vport_q <= '0;
      out_type_q  <= '0;
      out_addr_q  <= '0;
      out_src_q   <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      if (out_valid_q && out_ready) begin
        if (out_match_q) hit_q  <= hit_q + 32'd1;
        else             miss_q <= miss_q + 32'd1;
      end
      if (load) begin
        out_valid_q <= 1'b1;
        out_match_q <= win_entry[EW-1];
        out_port_q  <= win_entry[A+2+W +: W];
        out_vport_q <= win_entry[A+2 +: W];
        out_type_q  <= win_entry[A +: 2];
        out_addr_q  <= win_entry[A-1:0];
        out_src_q   <= win_idx;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign src_ready      = src_ready_q;
  assign out_valid      = out_valid_q;
  assign out_match      = out_match_q;
  assign out_port       = out_port_q;
  assign out_vport      = out_vport_q;
  assign out_type       = out_type_q;
  assign out_match_addr = out_addr_q;
  assign out_src        = out_src_q;
  assign timeout_err    = timeout_err_q;
  assign hit_cnt        = hit_q;
  assign miss_cnt       = miss_q;

endmodule

// File: tb/tb_match_result_collector.sv
// Scoreboard bench for match_result_collector: a per-source model pairs
// accepted beats, resolves priority and queues the expected outputs.
module tb_match_result_collector;

  typedef struct packed {
    logic       m;
    logic [7:0] port;
    logic [7:0] vport;
    logic [1:0] typ;
    logic [9:0] addr;
  } ent_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  src_valid = '0;
  logic [1:0]  src_ready;
  logic [1:0]  src_match = '0;
  logic [15:0] src_port = '0;
  logic [15:0] src_vport = '0;
  logic [3:0]  src_type = '0;
  logic [19:0] src_match_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_match;
  logic [7:0]  out_port, out_vport;
  logic [1:0]  out_type;
  logic [9:0]  out_match_addr;
  logic [0:0]  out_src;
  logic        timeout_err;
  logic [31:0] hit_cnt, miss_cnt;

  int vectors = 0;
  int miscompares = 0;
  int n_out = 0;
  int exp_hit = 0;
  int exp_miss = 0;
  ent_t q0[$];
  ent_t q1[$];
  logic [29:0] exp_q[$];

  match_result_collector dut (
    .clk(clk), .resetn(resetn),
    .src_valid(src_valid), .src_ready(src_ready), .src_match(src_match),
    .src_port(src_port), .src_vport(src_vport), .src_type(src_type),
    .src_match_addr(src_match_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_match(out_match),
    .out_port(out_port), .out_vport(out_vport), .out_type(out_type),
    .out_match_addr(out_match_addr), .out_src(out_src),
    .timeout_err(timeout_err), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] resolve(input ent_t e0, input ent_t e1);
    if (e0.m)      return {e0, 1'b0};
    else if (e1.m) return {e1, 1'b1};
    else           return 30'd0;
  endfunction

  task automatic pair_model();
    while (q0.size() > 0 && q1.size() > 0)
      exp_q.push_back(resolve(q0.pop_front(), q1.pop_front()));
  endtask

  function automatic logic [29:0] dut_out();
    return {out_match, out_port, out_vport, out_type, out_match_addr, out_src};
  endfunction

  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'(dut_out()), 64'h0);
        chk("unexpected_out_valid", 64'(out_valid), 64'h0);
      end else begin
        logic [29:0] e;
        e = exp_q.pop_front();
        chk("out_result", 64'(dut_out()), 64'(e));
        if (e[29]) exp_hit++;
        else       exp_miss++;
        n_out++;
      end
    end
  end

  // Called right after a rising edge (+1); returns the same way.
  task automatic send2(input logic [1:0] mask, input ent_t e0, input ent_t e1);
    logic [1:0] pend, acc;
    int n;
    pend = mask;
    n = 0;
    src_match      = {e1.m, e0.m};
    src_port       = {e1.port, e0.port};
    src_vport      = {e1.vport, e0.vport};
    src_type       = {e1.typ, e0.typ};
    src_match_addr = {e1.addr, e0.addr};
    while (pend != 2'b00 && n < 200) begin
      src_valid = pend;
      acc = pend & src_ready;
      @(posedge clk); #1;
      if (acc[0]) q0.push_back(e0);
      if (acc[1]) q1.push_back(e1);
      pair_model();
      pend = pend & ~acc;
      n++;
    end
    src_valid = 2'b00;
    if (pend != 2'b00) chk("send_bound", 64'(pend), 64'h0);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin cycles(1); n++; end
    cycles(2);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_hit"}, 64'(hit_cnt), 64'(exp_hit));
    chk({tag, "_miss"}, 64'(miss_cnt), 64'(exp_miss));
  endtask

  function automatic ent_t mk(input logic m, input logic [7:0] p, input logic [7:0] vp,
                              input logic [1:0] t, input logic [9:0] a);
    ent_t e;
    e.m = m; e.port = p; e.vport = vp; e.typ = t; e.addr = a;
    return e;
  endfunction

  initial begin
    ent_t z;
    int n;
    logic seen;
    z = '0;

    // reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_timeout", 64'(timeout_err), 64'h0);
    chk("rst_counts", {hit_cnt, miss_cnt}, 64'h0);
    chk("rst_data", 64'(dut_out()), 64'h0);
    chk("rst_src_ready", 64'(src_ready), 64'h0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    chk("src_ready_after_rst", 64'(src_ready), 64'h3);

    // both match in the same cycle: source 0 wins, two-edge latency
    out_ready = 1'b1;
    send2(2'b11, mk(1'b1, 8'h04, 8'h00, 2'd1, 10'd5), mk(1'b1, 8'h10, 8'h00, 2'd0, 10'd9));
    chk("lat_edge_k", 64'(out_valid), 64'h0);
    cycles(1);
    chk("lat_edge_k1", 64'(out_valid), 64'h1);
    drain();
    chk_counts("t1");
    chk("t1_hit_abs", 64'(hit_cnt), 64'd1);

    // source 0 miss, source 1 match arrives 3 cycles later
    send2(2'b01, mk(1'b0, 8'h55, 8'h66, 2'd2, 10'd3), z);
    cycles(3);
    chk("t2_no_early_out", 64'(out_valid), 64'h0);
    send2(2'b10, z, mk(1'b1, 8'h02, 8'h07, 2'd3, 10'd17));
    drain();
    chk_counts("t2");

    // both miss: data zeroed
    send2(2'b11, mk(1'b0, 8'hAA, 8'hBB, 2'd1, 10'd1), mk(1'b0, 8'hCC, 8'hDD, 2'd2, 10'd2));
    drain();
    chk_counts("t3");
    chk("t3_miss_abs", 64'(miss_cnt), 64'd1);

    // backpressure: 6 packets per source with out_ready held low
    out_ready = 1'b0;
    n = n_out;
    fork
      begin
        for (int j = 0; j < 6; j++)
          send2(2'b11, mk(j[0], 8'(8'h40 + j), 8'(j), 2'(j), 10'(100 + j)),
                       mk(1'b1, 8'(8'h20 + j), 8'(8'h80 + j), 2'd2, 10'(200 + j)));
      end
      begin
        cycles(20);
        chk("bp_src_ready", 64'(src_ready), 64'h0);
        for (int k = 0; k < 5; k++) begin
          chk("bp_valid_hold", 64'(out_valid), 64'h1);
          chk("bp_data_hold", 64'(dut_out()), 64'(exp_q[0]));
          cycles(1);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(n_out - n), 64'd6);
    chk_counts("t4");

    // watchdog: lone beat on source 0 is flushed
    send2(2'b01, mk(1'b1, 8'h33, 8'h00, 2'd1, 10'd7), z);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      cycles(1);
      n++;
      if (timeout_err) seen = 1'b1;
    end
    chk("wd_seen", 64'(seen), 64'h1);
    chk("wd_in_window", 64'(n >= 255 && n <= 257), 64'h1);
    chk("wd_no_out", 64'(out_valid), 64'h0);
    cycles(1);
    chk("wd_one_cycle", 64'(timeout_err), 64'h0);
    q0.delete();
    send2(2'b11, mk(1'b0, 8'h01, 8'h01, 2'd1, 10'd1), mk(1'b1, 8'h09, 8'h0A, 2'd3, 10'd300));
    drain();
    chk_counts("t5");

    // reset with pending output and partially full FIFOs
    out_ready = 1'b0;
    send2(2'b11, mk(1'b1, 8'h11, 8'h12, 2'd1, 10'd11), mk(1'b0, 8'h00, 8'h00, 2'd0, 10'd0));
    send2(2'b11, mk(1'b1, 8'h21, 8'h22, 2'd1, 10'd21), mk(1'b0, 8'h00, 8'h00, 2'd0, 10'd0));
    send2(2'b01, mk(1'b1, 8'h31, 8'h32, 2'd1, 10'd31), z);
    chk("mid_valid_before", 64'(out_valid), 64'h1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_data", 64'(dut_out()), 64'h0);
    chk("mid_rst_counts", {hit_cnt, miss_cnt}, 64'h0);
    chk("mid_rst_ready", 64'(src_ready), 64'h0);
    q0.delete(); q1.delete(); exp_q.delete();
    exp_hit = 0; exp_miss = 0;
    @(negedge clk); resetn = 1'b1;
    cycles(1);
    out_ready = 1'b1;
    send2(2'b11, mk(1'b0, 8'h00, 8'h00, 2'd0, 10'd0), mk(1'b1, 8'h77, 8'h78, 2'd2, 10'd512));
    drain();
    chk("post_rst_hit", 64'(hit_cnt), 64'd1);
    chk_counts("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/match_result_collector.md
Name: match_result_collector

Overview:
- Sequences N parallel lookup engines (exact table, wildcard table, ...) that return per-packet results with different, variable latencies.
- Buffers each engine's results in a per-source FIFO and aligns them per packet.
- Resolves priority (lowest source index wins) and emits one registered, handshaked action per packet to the action processor.
- Adds a stall watchdog and hit/miss statistics.

Parameters:
- C_NUM_SRC, 2, number of lookup sources; index 0 has the highest priority.
- C_OUT_PORT_WIDTH, 8, width of the port and vport fields.
- C_MATCH_ADDR_WIDTH, 10, width of the match address.
- C_FIFO_DEPTH, 4, per-source result FIFO depth; power of 2, at least 2.
- C_TIMEOUT, 255, watchdog limit in cycles; must be less than 2^16.

Ports:
- clk, in, 1: single clock.
- resetn, in, 1: asynchronous active-low reset.
- src_valid, in, C_NUM_SRC: per-source result valid.
- src_ready, out, C_NUM_SRC: per-source ready; high when that source's FIFO is not full.
- src_match, in, C_NUM_SRC: source found a match.
- src_port, in, C_NUM_SRC*C_OUT_PORT_WIDTH: flattened; source i occupies slice [i*W +: W].
- src_vport, in, C_NUM_SRC*C_OUT_PORT_WIDTH: flattened, same slicing.
- src_type, in, 2*C_NUM_SRC: 2-bit action type per source.
- src_match_addr, in, C_NUM_SRC*C_MATCH_ADDR_WIDTH: flattened.
- out_valid, out, 1: resolved result valid.
- out_ready, in, 1: downstream accept.
- out_match, out, 1: winning result matched.
- out_port, out, C_OUT_PORT_WIDTH.
- out_vport, out, C_OUT_PORT_WIDTH.
- out_type, out, 2.
- out_match_addr, out, C_MATCH_ADDR_WIDTH.
- out_src, out, clog2(C_NUM_SRC) (minimum 1): index of the winning source; 0 on a miss.
- timeout_err, out, 1: one-cycle pulse on a watchdog flush.
- hit_cnt, out, 32: count of emitted results with match = 1.
- miss_cnt, out, 32: count of emitted results with match = 0.

Behaviour:
- Reset (resetn = 0, async): all FIFOs empty. out_valid, timeout_err and both counters are 0. All output data fields are 0. src_ready is 0 while in reset and goes to all-1 on the first clock after release.
- Source handshake: a beat is written when src_valid[i] && src_ready[i] at a rising edge. Results from each source arrive in packet order.
- FIFO full: src_ready[i] is deasserted when FIFO i is full. No write occurs. A pop and a push in the same cycle on a full FIFO are not both allowed; src_ready is computed from the registered full flag only.
- all_rdy: all FIFOs are non-empty.
- Load condition: all_rdy && (!out_valid || out_ready). On load, every FIFO head is popped and the output registers are loaded. The winner is the lowest i whose head has match = 1.
  - Winner found: out_match = 1, out_src = i, and data comes from head i.
  - No winner: out_match = 0, out_src = 0, out_port/out_vport/out_type/out_match_addr = 0.
- Latency: the beat that completes all_rdy is accepted at edge k; out_valid is high after edge k+1. Throughput is one result per cycle while out_ready = 1.
- Backpressure: out_valid together with out_data stays stable until out_ready. A pop occurs in the same cycle as the downstream accept if the next set is complete. When !all_rdy && out_ready, out_valid falls.
- Watchdog: a 16-bit counter increments each cycle in which at least one FIFO, but not all, is non-empty.
  - It clears on every load and whenever all FIFOs are empty.
  - When it reaches C_TIMEOUT: pop the head of every non-empty FIFO, emit nothing, pulse timeout_err for one cycle, and clear the counter.
  - Load takes precedence over timeout in the same cycle.
- Counters: hit_cnt/miss_cnt increment on the output handshake (out_valid && out_ready), not on load. They wrap at 2^32.
- Reset mid-operation: FIFOs are flushed, any pending output is dropped, and counters are zeroed.

Test Plan:
- Source 0 result {match=1, port=0x04, type=1, addr=5} and source 1 result {match=1, port=0x10} in the same cycle, out_ready = 1 -> out_port = 0x04, out_src = 0, out_match_addr = 5, out_valid 2 edges after input, hit_cnt = 1.
- Source 0 miss, source 1 {match=1, port=0x02, vport=0x07} arriving 3 cycles later -> output only after the source 1 beat, out_port = 0x02, out_vport = 0x07, out_src = 1.
- Both sources miss -> out_match = 0, all data fields 0, miss_cnt = 1.
- Hold out_ready = 0 and stream 6 packets per source with C_FIFO_DEPTH = 4 -> src_ready drops after the FIFO fills; out_data stays stable. Then release out_ready -> all 6 results emerge in order, with no loss or duplication.
- Source 0 sends 1 beat and source 1 stays silent for C_TIMEOUT = 255 cycles -> timeout_err pulses at cycle 255, FIFO 0 is empty, no out_valid. A subsequent complete pair is emitted normally.
- Assert resetn = 0 while out_valid = 1 and the FIFOs are partially full -> all outputs 0 immediately; after release, the first new pair yields a correct result and hit_cnt = 1.
